seg7_write_arbiter: RTL and testbench
=====================================

// Module: seg7_write_arbiter
// PURPOSE
//  Shares the single write port of the 7-segment display driver (enable/rw/addr/data)
//  between NREQ bus masters, e.g. CPU and debug monitor. Round-robin arbitration with
//  req/ack handshake. Registered single-cycle write strobes toward the display.
//  Out-of-window addresses are acked and discarded. Optional ownership lock
//  keeps one master on the display for a fixed window.
// PARAMETERS
//  NREQ       2          number of requesters, legal 2..4
//  BASE       16         first display register address; window is [BASE, BASE+2)
//  LOCK_CYCS  1024       ownership window length in clk cycles (SEG7_ARB_LOCK_EN only), >=1
// PORTS
//  clk        in   1          system clock
//  reset_n    in   1          asynchronous active-low reset
//  req        in   NREQ       per-master write request, level, held until ack
//  req_addr   in   32*NREQ    master i address in bits [32*i +: 32]
//  req_data   in   32*NREQ    master i data in bits [32*i +: 32]
//  ack        out  NREQ       one-cycle pulse, request consumed
//  seg_enable out  1          write strobe to display driver
//  seg_rw     out  1          1 = write; equals seg_enable
//  seg_addr   out  32         display register address
//  seg_data   out  32         display register data
//  owner      out  2          index of last granted master
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, ack=0, seg_enable=0, seg_rw=0,
//    seg_addr=0, seg_data=0, owner=0, rr pointer=0, lock counter=0.
//  - FSM IDLE -> GRANT -> GAP -> IDLE. All outputs registered.
//  - IDLE: if any eligible req, pick winner: first set bit scanning from (owner+1) mod NREQ
//    upward with wrap; register winner's addr/data, owner<=winner; go GRANT. Else stay.
//  - GRANT (1 cycle): ack[owner]=1. If BASE<=seg_addr<BASE+2: seg_enable=seg_rw=1,
//    else both 0 (dropped write, still acked). Go GAP.
//  - GAP (1 cycle): all strobes 0; req inputs ignored so the acked master can drop req. -> IDLE.
//  - Latency: req seen high in IDLE at edge N -> strobe+ack during cycle N+1; peak rate
//    one write per 3 cycles. Master must deassert req, or present a new addr/data, by the
//    cycle after ack.
//  - seg_addr/seg_data hold last value when idle; only seg_enable qualifies them.
//  - req deasserted before grant: withdrawn, no ack, no strobe.
//  - Simultaneous reqs: round-robin from owner+1. With owner=0: master 1 wins, then master 0.
//  - Out-of-range req_addr (e.g. 0, BASE+2, 0xFFFFFFFF): ack pulse, seg_enable stays 0;
//    still updates owner and rr pointer.
//  - reset_n low mid-GRANT: strobe and ack drop immediately, write considered lost.
// CONFIGURATION
//  SEG7_ARB_LOCK_EN defined: a grant to master w while lock counter==0 loads
//   counter=LOCK_CYCS-1 and lock owner=w. Counter decrements each cycle to 0. While
//   nonzero, only lock owner is eligible in IDLE; other reqs wait (no ack). Owner writes
//   during the window do NOT reload the counter, so wait for others is bounded by
//   LOCK_CYCS+3 cycles. Window expiry with lock owner's req pending: normal round-robin
//   from owner+1.
//  SEG7_ARB_LOCK_EN undefined: no counter, pure round-robin every grant; LOCK_CYCS unused.
// TESTING
//  1. Reset, req[0]=1, addr=16, data=0x1234 -> cycle+1: seg_enable=1, seg_addr=16,
//     seg_data=0x1234, ack=01; one strobe only.
//  2. req=11 together, owner=0, addrs 16/17 -> master 1 strobes first, master 0 three
//     cycles later; owner 1 then 0.
//  3. req[1] addr=18 -> ack[1] pulses, seg_enable stays 0; owner=1.
//  4. Hold req[0] with new data after each ack -> strobes exactly every 3 cycles, no dup.
//  5. LOCK_EN, LOCK_CYCS=8: master 0 granted, req[1] raised next cycle -> no ack[1] until
//     counter hits 0; then granted within 3 cycles. Without macro: granted in next IDLE.
//  6. reset_n low during GRANT -> seg_enable, ack, owner are 0 the same cycle;
//     after release, pending req re-arbitrates.

Source files
------------

// File: rtl/seg7_write_arbiter.sv
// seg7_write_arbiter: shares the single write port of the 7-segment display
// driver between NREQ bus masters. Round-robin arbitration with a req/ack
// handshake, and registered single-cycle write strobes toward the display.
// Writes whose address falls outside [BASE, BASE+2) are acknowledged and
// discarded.
//
// Optional feature, enabled by defining SEG7_ARB_LOCK_EN: an ownership lock
// that keeps one master on the display for LOCK_CYCS cycles after it wins a
// grant while the lock is free. Without the macro, every grant is pure
// round-robin and LOCK_CYCS only goes through the parameter legality check.
module seg7_write_arbiter #(
  parameter int NREQ      = 2,
  parameter int BASE      = 16,
  parameter int LOCK_CYCS = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              seg_enable,
  output logic              seg_rw,
  output logic [31:0]       seg_addr,
  output logic [31:0]       seg_data,
  output logic [1:0]        owner
);

  // Reject illegal parameter values when the design is elaborated.
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("seg7_write_arbiter: NREQ must be 2..4");
  end
  if (LOCK_CYCS < 1) begin : g_bad_lock
    $error("seg7_write_arbiter: LOCK_CYCS must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t       state;

  // Request vectors padded to the four-master maximum, so that a 2-bit
  // master index can select from them at any legal NREQ.
  logic [3:0]   req4;
  logic [127:0] addr4;
  logic [127:0] data4;

  logic [3:0]   elig;
  logic [1:0]   cand;
  logic         found;
  logic [1:0]   win_idx;
  logic [31:0]  win_addr;
  logic [31:0]  win_data;
  logic         win_in_window;

  assign req4  = 4'(req);
  assign addr4 = 128'(req_addr);
  assign data4 = 128'(req_data);

`ifdef SEG7_ARB_LOCK_EN
  localparam int CW = (LOCK_CYCS > 1) ? $clog2(LOCK_CYCS) : 1;

  logic [CW-1:0] lock_cnt;
  logic [1:0]    lock_owner;

  // While the lock window is open, only the lock owner may compete.
  always_comb begin
    elig = req4;
    if (lock_cnt != '0) elig = req4 & (4'b0001 << lock_owner);
  end

  // Lock window: armed by a grant while free, then counts down to zero.
  // The owner's own grants inside the window do not re-arm it, which bounds
  // how long the other masters can be held off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt   <= '0;
      lock_owner <= '0;
    end else if (state == S_IDLE && found && lock_cnt == '0) begin
      lock_cnt   <= CW'(LOCK_CYCS - 1);
      lock_owner <= win_idx;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - CW'(1);
    end
  end
`else
  // Without the lock, every requester is always eligible.
  always_comb begin
    elig = req4;
  end
`endif

  // Round-robin pick: first eligible master scanning upward from owner+1,
  // wrapping, so the previous winner is considered last. owner therefore
  // doubles as the round-robin pointer.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // that no path leaves it holding a value, which would infer a latch.
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 2'((int'(owner) + k) % NREQ);
      if (!found && elig[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_addr      = addr4[{win_idx, 5'b0} +: 32];
    win_data      = data4[{win_idx, 5'b0} +: 32];
    win_in_window = (win_addr >= 32'(BASE)) && (win_addr < 32'(BASE + 2));
  end

  // Arbiter FSM with registered outputs: IDLE picks a winner and loads the
  // strobe/ack for the following GRANT cycle; GAP ignores req so the acked
  // master has a cycle to drop or replace its request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ack        <= '0;
      seg_enable <= 1'b0;
      seg_rw     <= 1'b0;
      seg_addr   <= '0;
      seg_data   <= '0;
      owner      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (found) begin
            seg_addr   <= win_addr;
            seg_data   <= win_data;
            owner      <= win_idx;
            ack        <= NREQ'(1) << win_idx;
            seg_enable <= win_in_window;
            seg_rw     <= win_in_window;
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          ack        <= '0;
          seg_enable <= 1'b0;
          seg_rw     <= 1'b0;
          state      <= S_GAP;
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          ack        <= '0;
          seg_enable <= 1'b0;
          seg_rw     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_write_arbiter.sv
// tb_seg7_write_arbiter: directed self-checking bench for seg7_write_arbiter
// with two masters, BASE=16 and LOCK_CYCS=8. Expected grant latencies depend
// on whether SEG7_ARB_LOCK_EN is defined.
module tb_seg7_write_arbiter;

  localparam int NREQ      = 2;
  localparam int BASE      = 16;
  localparam int LOCK_CYCS = 8;
`ifdef SEG7_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif
  // Cycles from one grant edge until another master waiting on it is granted.
  localparam int OTHER_LAT = LOCK_ON ? LOCK_CYCS : 3;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              seg_enable;
  logic              seg_rw;
  logic [31:0]       seg_addr;
  logic [31:0]       seg_data;
  logic [1:0]        owner;

  int n_checks = 0;
  int n_errors = 0;

  seg7_write_arbiter #(
    .NREQ     (NREQ),
    .BASE     (BASE),
    .LOCK_CYCS(LOCK_CYCS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ack       (ack),
    .seg_enable(seg_enable),
    .seg_rw    (seg_rw),
    .seg_addr  (seg_addr),
    .seg_data  (seg_data),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are then sampled 1 time unit after the edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] d);
    req_addr[32*i +: 32] = a;
    req_data[32*i +: 32] = d;
  endtask

  // Count edges until ack[idx] is seen; n stays -1 if the bound expires.
  task automatic wait_ack(input int idx, input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      cyc();
      if (ack[idx] === 1'b1) begin
        n = c;
        break;
      end
    end
  endtask

  logic [31:0] oor_addr [5] = '{32'h0000_0000, 32'h0000_000F, 32'h0000_0012,
                                32'hFFFF_FFFF, 32'h0000_0011};
  logic        oor_en   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] d4       [3] = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003};

  initial begin
    int lat;
    reset_n  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;

    // Reset state
    #12;
    check("rst_enable", seg_enable, 0);
    check("rst_rw",     seg_rw,     0);
    check("rst_ack",    ack,        0);
    check("rst_addr",   seg_addr,   0);
    check("rst_data",   seg_data,   0);
    check("rst_owner",  owner,      0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);

    // 1: single write from master 0, strobe on the next cycle, exactly once
    set_m(0, 32'd16, 32'h0000_1234);
    req = 2'b01;
    cyc();
    check("t1_enable", seg_enable, 1);
    check("t1_rw",     seg_rw,     1);
    check("t1_ack",    ack,        2'b01);
    check("t1_addr",   seg_addr,   32'd16);
    check("t1_data",   seg_data,   32'h0000_1234);
    check("t1_owner",  owner,      0);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t1_no_dup_en",  seg_enable, 0);
      check("t1_no_dup_ack", ack,        0);
    end
    check("t1_addr_hold", seg_addr, 32'd16);
    cyc(10);

    // 2: simultaneous requests with owner=0 -> master 1 first, then master 0
    set_m(0, 32'd16, 32'hA000_0000);
    set_m(1, 32'd17, 32'hB000_0001);
    req = 2'b11;
    cyc();
    check("t2_first_ack",   ack,      2'b10);
    check("t2_first_en",    seg_enable, 1);
    check("t2_first_addr",  seg_addr, 32'd17);
    check("t2_first_data",  seg_data, 32'hB000_0001);
    check("t2_first_owner", owner,    1);
    req = 2'b01;
    wait_ack(0, 40, lat);
    check("t2_second_lat",   lat,        OTHER_LAT);
    check("t2_second_en",    seg_enable, 1);
    check("t2_second_addr",  seg_addr,   32'd16);
    check("t2_second_data",  seg_data,   32'hA000_0000);
    check("t2_second_owner", owner,      0);
    req = 2'b00;
    cyc(10);

    // 3: out-of-window addresses are acked but never strobed; BASE+1 is in window
    for (int i = 0; i < 5; i++) begin
      set_m(1, oor_addr[i], 32'hC000_0000 + 32'(i));
      req = 2'b10;
      cyc();
      check("t3_ack",   ack,        2'b10);
      check("t3_en",    seg_enable, oor_en[i]);
      check("t3_rw",    seg_rw,     oor_en[i]);
      check("t3_owner", owner,      1);
      req = 2'b00;
      cyc(2);
    end

    // Withdrawn request: raised and dropped before any IDLE edge sees it
    req = 2'b01;
    #3;
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wd_ack", ack,        0);
      check("wd_en",  seg_enable, 0);
    end
    cyc(10);

    // 4: master 0 holds req with new data after each ack -> one strobe per 3 cycles
    set_m(0, 32'd17, d4[0]);
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_en",   seg_enable, 1);
      check("t4_ack",  ack,        2'b01);
      check("t4_data", seg_data,   d4[i]);
      if (i < 2) set_m(0, 32'd17, d4[i+1]);
      else       req = 2'b00;
      cyc();
      check("t4_gap1_en", seg_enable, 0);
      cyc();
      check("t4_gap2_en", seg_enable, 0);
    end
    cyc(10);

    // 5: master 0 granted, master 1 raised the next cycle
    set_m(0, 32'd16, 32'h5000_0000);
    set_m(1, 32'd17, 32'h5000_0001);
    req = 2'b01;
    cyc();
    check("t5_m0_ack", ack, 2'b01);
    req = 2'b10;
    wait_ack(1, 40, lat);
    check("t5_m1_lat",   lat,      OTHER_LAT);
    check("t5_m1_owner", owner,    1);
    check("t5_m1_data",  seg_data, 32'h5000_0001);
    req = 2'b00;
    cyc(10);

    // 6: reset asserted during GRANT drops strobe/ack/owner at once,
    //    and the still-pending request re-arbitrates afterwards
    set_m(1, 32'd17, 32'h6000_0001);
    req = 2'b10;
    cyc();
    check("t6_pre_en",    seg_enable, 1);
    check("t6_pre_owner", owner,      1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_en",    seg_enable, 0);
    check("t6_rst_ack",   ack,        0);
    check("t6_rst_owner", owner,      0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack(1, 40, lat);
    check("t6_rearb_lat",   lat,        1);
    check("t6_rearb_en",    seg_enable, 1);
    check("t6_rearb_owner", owner,      1);
    check("t6_rearb_data",  seg_data,   32'h6000_0001);
    req = 2'b00;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
